// File: rtl/stopwatch_pkg.sv
// Shared state encodings, default divisors and a state-class helper for the
// stopwatch control path.
package stopwatch_pkg;

    localparam logic [1:0] ST_RUN     = 2'd0;
    localparam logic [1:0] ST_PAUSED  = 2'd1;
    localparam logic [1:0] ST_ADJ_MIN = 2'd2;
    localparam logic [1:0] ST_ADJ_SEC = 2'd3;

    localparam int DEF_DIV_CNT   = 100_000_000;
    localparam int DEF_DIV_ADJ   = 50_000_000;
    localparam int DEF_DIV_BLINK = 25_000_000;

    // Both adjust encodings have the MSB set.
    function automatic logic is_adj(input logic [1:0] s);
        return s[1];
    endfunction

endpackage

// File: rtl/tick_divider.sv
// Modulo-DIV cycle counter with hold enable and synchronous clear.
// tick is asserted combinationally on the enabled cycle that wraps the count.
module tick_divider #(
    parameter int DIV = 2
) (
    input  logic clk,
    input  logic rst,
    input  logic en,
    input  logic clr,
    output logic tick
);

    localparam int W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [W-1:0] LAST = W'(DIV - 1);

    logic [W-1:0] cnt;

    always_ff @(posedge clk) begin
        if (!rst) begin
            cnt <= '0;
        end else if (clr) begin
            cnt <= '0;
        end else if (en) begin
            cnt <= (cnt == LAST) ? '0 : cnt + W'(1);
        end
    end

    // A clear on the wrap cycle swallows the tick.
    assign tick = en & ~clr & (cnt == LAST);

endmodule

// File: rtl/stopwatch_ctrl.sv
// Run/pause/adjust sequencer for the mm:ss counter: edge-detects the buttons,
// owns the three time-base dividers and drives registered strobes and blink enables.
module stopwatch_ctrl
    import stopwatch_pkg::*;
#(
    parameter int DIV_CNT   = DEF_DIV_CNT,
    parameter int DIV_ADJ   = DEF_DIV_ADJ,
    parameter int DIV_BLINK = DEF_DIV_BLINK
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       clr_btn,
    input  logic       pause_btn,
    input  logic       adj_sw,
    input  logic       sel_sw,
    output logic       cnt_clr,
    output logic       sec_inc,
    output logic       min_inc,
    output logic       carry_en,
    output logic       blink_min,
    output logic       blink_sec,
    output logic [1:0] state
);

    logic       clr_prev, pause_prev, paused, phase;
    logic       clr_edge, pause_edge, paused_n, phase_n, adj_clr;
    logic       cnt_tick, adj_tick, blink_tick;
    logic [1:0] nxt;

    // paused always mirrors RUN/PAUSED outside adjust, so one next-state
    // expression covers every state.
    always_comb begin
        clr_edge   = clr_btn & ~clr_prev;
        pause_edge = pause_btn & ~pause_prev;
        paused_n   = paused ^ pause_edge;
        if (adj_sw) nxt = sel_sw ? ST_ADJ_SEC : ST_ADJ_MIN;
        else        nxt = paused_n ? ST_PAUSED : ST_RUN;
        adj_clr    = clr_edge | ~is_adj(state) | (nxt != state);
        phase_n    = phase ^ blink_tick;
    end

    tick_divider #(.DIV(DIV_CNT)) u_cnt (
        .clk(clk), .rst(rst), .en(state == ST_RUN), .clr(clr_edge), .tick(cnt_tick)
    );

    tick_divider #(.DIV(DIV_ADJ)) u_adj (
        .clk(clk), .rst(rst), .en(is_adj(state)), .clr(adj_clr), .tick(adj_tick)
    );

    tick_divider #(.DIV(DIV_BLINK)) u_blink (
        .clk(clk), .rst(rst), .en(1'b1), .clr(1'b0), .tick(blink_tick)
    );

    always_ff @(posedge clk) begin
        if (!rst) begin
            state      <= ST_PAUSED;
            paused     <= 1'b1;
            clr_prev   <= 1'b1;
            pause_prev <= 1'b1;
            phase      <= 1'b0;
            cnt_clr    <= 1'b1;
            sec_inc    <= 1'b0;
            min_inc    <= 1'b0;
            carry_en   <= 1'b0;
            blink_min  <= 1'b0;
            blink_sec  <= 1'b0;
        end else begin
            state      <= nxt;
            paused     <= paused_n;
            clr_prev   <= clr_btn;
            pause_prev <= pause_btn;
            phase      <= phase_n;
            cnt_clr    <= clr_edge;
            sec_inc    <= ((state == ST_RUN) & cnt_tick) | ((state == ST_ADJ_SEC) & adj_tick);
            min_inc    <= (state == ST_ADJ_MIN) & adj_tick;
            // Look-ahead on nxt keeps these aligned with the state output.
            carry_en   <= ~is_adj(nxt);
            blink_min  <= (nxt == ST_ADJ_MIN) & phase_n;
            blink_sec  <= (nxt == ST_ADJ_SEC) & phase_n;
        end
    end

endmodule
